// File: rtl/lstm_accel_pkg.sv
// lstm_accel_pkg: shape constants, index/address widths and enums shared by the LSTM sequencer.
package lstm_accel_pkg;
   localparam int NO_UNITS     = 2;
   localparam int NO_FEATURES  = 3;
   localparam int NO_TIMESTEPS = 2;
   localparam int N_GATES      = 4;
   function automatic int clog2_min1(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int WA = clog2_min1(NO_UNITS * N_GATES * NO_FEATURES);
   localparam int XA = clog2_min1(NO_TIMESTEPS * NO_FEATURES);
   localparam int BA = clog2_min1(NO_UNITS * N_GATES);
   localparam int UA = clog2_min1(NO_UNITS);
   localparam int TA = clog2_min1(NO_TIMESTEPS);
   localparam int GA = clog2_min1(N_GATES);
   localparam int FA = clog2_min1(NO_FEATURES);
   typedef enum logic [1:0] {GATE_I, GATE_F, GATE_G, GATE_O} gate_e;
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_GATE = 3'd2,
      S_CELL      = 3'd3,
      S_WAIT_CELL = 3'd4,
      S_DONE      = 3'd5
   } seq_state_e;
endpackage

// File: rtl/lstm_seq_counter.sv
// lstm_seq_counter: nested t/u/g/f index counters; each wraps to 0 exactly at its limit.
module lstm_seq_counter
   import lstm_accel_pkg::*;
(
   input  logic          clk,
   input  logic          rst_i,
   input  logic          clr,
   input  logic          inc_f,
   input  logic          inc_g,
   input  logic          inc_u,
   output logic [TA-1:0] t,
   output logic [UA-1:0] u,
   output logic [GA-1:0] g,
   output logic [FA-1:0] f,
   output logic          f_last,
   output logic          g_last,
   output logic          u_last,
   output logic          t_last
);
   assign f_last = f == FA'(NO_FEATURES - 1);
   assign g_last = g == GA'(N_GATES - 1);
   assign u_last = u == UA'(NO_UNITS - 1);
   assign t_last = t == TA'(NO_TIMESTEPS - 1);
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         {t, u, g, f} <= '0;
      end else if (clr) begin
         {t, u, g, f} <= '0;
      end else begin
         if (inc_f) f <= f_last ? '0 : f + 1'b1;
         if (inc_g) g <= g_last ? '0 : g + 1'b1;
         if (inc_u) begin
            u <= u_last ? '0 : u + 1'b1;
            if (u_last) t <= t_last ? '0 : t + 1'b1;
         end
      end
   end
endmodule

// File: rtl/lstm_sequencer.sv
// lstm_sequencer: FSM stepping the LSTM MAC datapath over t/u/g/f for one inference.
// Define LSTM_SEQ_PERF_CNT_EN to add saturating busy/stall performance counters.
module lstm_sequencer
   import lstm_accel_pkg::*;
(
   input  logic          clk,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic          load_done_i,
   output logic          mac_valid_o,
   input  logic          mac_ready_i,
   output logic          mac_first_o,
   output logic          mac_last_o,
   output logic [WA-1:0] w_addr_o,
   output logic [XA-1:0] x_addr_o,
   output logic [BA-1:0] b_addr_o,
   input  logic          gate_res_valid_i,
   output logic          cell_upd_o,
   output logic [UA-1:0] cell_unit_o,
   input  logic          cell_done_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [TA-1:0] step_t_o
`ifdef LSTM_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]   perf_cycles_o,
   output logic [31:0]   perf_stall_o
`endif
);
   seq_state_e    state, state_nx;
   logic [TA-1:0] t;
   logic [UA-1:0] u;
   logic [GA-1:0] g;
   logic [FA-1:0] f;
   logic          f_last, g_last, u_last, t_last;
   logic          go, hs, gate_ev, cell_ev;
   assign go      = state == S_IDLE && start_i && load_done_i;
   assign hs      = state == S_ISSUE && mac_ready_i;
   assign gate_ev = state == S_WAIT_GATE && gate_res_valid_i;
   assign cell_ev = state == S_WAIT_CELL && cell_done_i;
   lstm_seq_counter u_cnt (
      .clk    (clk),
      .rst_i  (rst_i),
      .clr    (abort_i || go),
      .inc_f  (hs && !abort_i),
      .inc_g  (gate_ev && !abort_i),
      .inc_u  (cell_ev && !abort_i),
      .t      (t),
      .u      (u),
      .g      (g),
      .f      (f),
      .f_last (f_last),
      .g_last (g_last),
      .u_last (u_last),
      .t_last (t_last)
   );
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:      state_nx = go ? S_ISSUE : S_IDLE;
         S_ISSUE:     state_nx = hs && f_last ? S_WAIT_GATE : S_ISSUE;
         S_WAIT_GATE: state_nx = gate_ev ? (g_last ? S_CELL : S_ISSUE) : S_WAIT_GATE;
         S_CELL:      state_nx = S_WAIT_CELL;
         S_WAIT_CELL: state_nx = cell_ev ? (u_last && t_last ? S_DONE : S_ISSUE) : S_WAIT_CELL;
         default:     state_nx = S_IDLE;
      endcase
      if (abort_i) state_nx = S_IDLE;
   end
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else state <= state_nx;
   end
   // Addresses come straight from the counters, so they stay stable while a step is stalled.
   assign mac_valid_o = state == S_ISSUE;
   assign mac_first_o = mac_valid_o && f == '0;
   assign mac_last_o  = mac_valid_o && f_last;
   assign w_addr_o    = WA'((32'(u) * N_GATES + 32'(g)) * NO_FEATURES + 32'(f));
   assign x_addr_o    = XA'(32'(t) * NO_FEATURES + 32'(f));
   assign b_addr_o    = BA'(32'(u) * N_GATES + 32'(g));
   assign cell_upd_o  = state == S_CELL;
   assign cell_unit_o = u;
   assign busy_o      = state != S_IDLE;
   assign done_o      = state == S_DONE;
   assign step_t_o    = t;
`ifdef LSTM_SEQ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         perf_cycles_o <= '0;
         perf_stall_o  <= '0;
      end else if (go) begin
         perf_cycles_o <= '0;
         perf_stall_o  <= '0;
      end else begin
         if (busy_o && !(&perf_cycles_o)) perf_cycles_o <= perf_cycles_o + 1'b1;
         if (mac_valid_o && !mac_ready_i && !(&perf_stall_o)) perf_stall_o <= perf_stall_o + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_lstm_sequencer.sv
// tb_lstm_sequencer: directed self-checking bench for lstm_sequencer (perf checks when LSTM_SEQ_PERF_CNT_EN is defined).
module tb_lstm_sequencer;
   import lstm_accel_pkg::*;
   logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, load_done_i = 1'b0;
   logic mac_ready_i = 1'b0, gate_res_valid_i = 1'b0, cell_done_i = 1'b0;
   logic mac_valid_o, mac_first_o, mac_last_o, cell_upd_o, busy_o, done_o;
   logic [WA-1:0] w_addr_o;
   logic [XA-1:0] x_addr_o;
   logic [BA-1:0] b_addr_o;
   logic [UA-1:0] cell_unit_o;
   logic [TA-1:0] step_t_o;
`ifdef LSTM_SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles_o, perf_stall_o;
`endif
   int checks = 0, failures = 0;
   int hs_w[$], hs_x[$], hs_b[$], hs_fl[$], units[$];
   int n_done, n_stall, n_busy, n_viol, last_cell_cyc, done_cyc;
   bit timed_out, first_ok;
   int exp_w[48], exp_x[48], exp_b[48], exp_fl[48];

   lstm_sequencer dut (
      .clk(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .load_done_i(load_done_i),
      .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_first_o(mac_first_o), .mac_last_o(mac_last_o),
      .w_addr_o(w_addr_o), .x_addr_o(x_addr_o), .b_addr_o(b_addr_o),
      .gate_res_valid_i(gate_res_valid_i), .cell_upd_o(cell_upd_o), .cell_unit_o(cell_unit_o),
      .cell_done_i(cell_done_i), .busy_o(busy_o), .done_o(done_o), .step_t_o(step_t_o)
`ifdef LSTM_SEQ_PERF_CNT_EN
      , .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o)
`endif
   );

   always #5 clk = ~clk;

   // Emulates the datapath: gate result and cell done each answer one cycle after the request.
   task automatic run_seq(input bit bp, input bit spur, input int abort_hs);
      bit pg = 0, pc = 0, stalled = 0, ab = 0;
      logic [WA+XA+BA+2:0] snap = '0;
      int tail = -1, cyc = 0;
      hs_w.delete(); hs_x.delete(); hs_b.delete(); hs_fl.delete(); units.delete();
      n_done = 0; n_stall = 0; n_busy = 0; n_viol = 0; timed_out = 0; first_ok = 0;
      last_cell_cyc = -1; done_cyc = -1;
      while (1) begin
         @(negedge clk);
         start_i = 1'b0;
         if (cyc == 0) first_ok = mac_valid_o && mac_first_o && b_addr_o == '0 && w_addr_o == '0 && x_addr_o == '0;
         if (busy_o) n_busy++;
         if (done_o) begin n_done++; done_cyc = cyc; end
         if (stalled && {mac_valid_o, mac_first_o, mac_last_o, w_addr_o, x_addr_o, b_addr_o} !== snap) n_viol++;
         gate_res_valid_i = pg | (spur & mac_valid_o);
         cell_done_i = pc | (spur & pg);
         abort_i = ab;
         pg = 0;
         pc = 0;
         if (cell_upd_o) begin units.push_back(int'(cell_unit_o)); pc = 1; last_cell_cyc = cyc; end
         mac_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = mac_valid_o && !mac_ready_i;
         if (stalled) n_stall++;
         snap = {mac_valid_o, mac_first_o, mac_last_o, w_addr_o, x_addr_o, b_addr_o};
         if (mac_valid_o && mac_ready_i) begin
            hs_w.push_back(int'(w_addr_o));
            hs_x.push_back(int'(x_addr_o));
            hs_b.push_back(int'(b_addr_o));
            hs_fl.push_back(int'({mac_first_o, mac_last_o}));
            if (mac_last_o) pg = 1;
            if (hs_w.size() - 1 == abort_hs) ab = 1;
         end
         if (abort_i) break;
         if (done_o && tail < 0) tail = 3;
         if (tail == 0) break;
         if (tail > 0) tail--;
         if (++cyc > 3000) begin timed_out = 1; break; end
      end
      @(posedge clk);
      #1;
      {start_i, abort_i, gate_res_valid_i, cell_done_i, mac_ready_i} = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({mac_valid_o, mac_first_o, mac_last_o, w_addr_o, x_addr_o, b_addr_o, cell_upd_o, cell_unit_o, busy_o, done_o, step_t_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b busy=%b done=%b w=%0d want all 0", mac_valid_o, busy_o, done_o, w_addr_o);
      end
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle busy got %b want 0", busy_o); end
   endtask

   task automatic test_load_gate();
      start_i = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (busy_o !== 1'b0 || mac_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL load_gate_idle got busy=%b valid=%b want 0 0", busy_o, mac_valid_o);
         end
      end
      start_i = 1'b0;
      load_done_i = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      run_seq(0, 0, -1);
      checks++;
      if (first_ok !== 1'b1) begin failures++; $display("FAIL load_gate_first got %b want 1", first_ok); end
      checks++;
      if (timed_out || n_done !== 1) begin failures++; $display("FAIL load_gate_done got %0d timeout=%0d want 1", n_done, timed_out); end
   endtask

   task automatic test_nominal();
      int lasts = 0;
      @(negedge clk);
      start_i = 1'b1;
      run_seq(0, 0, -1);
      checks++;
      if (timed_out) begin failures++; $display("FAIL nominal_timeout got 1 want 0"); end
      checks++;
      if (hs_w.size() !== 48) begin failures++; $display("FAIL nominal_steps got %0d want 48", hs_w.size()); end
      for (int i = 0; i < hs_w.size() && i < 48; i++) begin
         checks++;
         if (hs_w[i] !== exp_w[i] || hs_x[i] !== exp_x[i] || hs_b[i] !== exp_b[i] || hs_fl[i] !== exp_fl[i]) begin
            failures++;
            $display("FAIL nominal_step%0d got w=%0d x=%0d b=%0d fl=%0d want w=%0d x=%0d b=%0d fl=%0d",
                     i, hs_w[i], hs_x[i], hs_b[i], hs_fl[i], exp_w[i], exp_x[i], exp_b[i], exp_fl[i]);
         end
         if (hs_fl[i] % 2 == 1) lasts++;
      end
      checks++;
      if (lasts !== 16) begin failures++; $display("FAIL nominal_gates got %0d want 16", lasts); end
      checks++;
      if (units.size() !== 4) begin failures++; $display("FAIL nominal_cell_count got %0d want 4", units.size()); end
      for (int i = 0; i < units.size() && i < 4; i++) begin
         checks++;
         if (units[i] !== i % 2) begin failures++; $display("FAIL nominal_cell_unit%0d got %0d want %0d", i, units[i], i % 2); end
      end
      checks++;
      if (n_done !== 1) begin failures++; $display("FAIL nominal_done got %0d want 1", n_done); end
      checks++;
      if (done_cyc - last_cell_cyc !== 2) begin failures++; $display("FAIL nominal_done_latency got %0d want 2", done_cyc - last_cell_cyc); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      start_i = 1'b1;
      run_seq(1, 0, -1);
      checks++;
      if (timed_out || n_done !== 1) begin failures++; $display("FAIL bp_done got %0d timeout=%0d want 1", n_done, timed_out); end
      checks++;
      if (n_viol !== 0) begin failures++; $display("FAIL bp_stable got %0d unstable stalls want 0", n_viol); end
      checks++;
      if (n_stall == 0) begin failures++; $display("FAIL bp_stalls got 0 stall cycles want >0"); end
      checks++;
      if (hs_w.size() !== 48) begin failures++; $display("FAIL bp_steps got %0d want 48", hs_w.size()); end
      for (int i = 0; i < hs_w.size() && i < 48; i++) begin
         checks++;
         if (hs_w[i] !== exp_w[i] || hs_x[i] !== exp_x[i] || hs_b[i] !== exp_b[i] || hs_fl[i] !== exp_fl[i]) begin
            failures++;
            $display("FAIL bp_step%0d got w=%0d x=%0d b=%0d fl=%0d want w=%0d x=%0d b=%0d fl=%0d",
                     i, hs_w[i], hs_x[i], hs_b[i], hs_fl[i], exp_w[i], exp_x[i], exp_b[i], exp_fl[i]);
         end
      end
`ifdef LSTM_SEQ_PERF_CNT_EN
      checks++;
      if (perf_stall_o !== 32'(n_stall)) begin failures++; $display("FAIL bp_perf_stall got %0d want %0d", perf_stall_o, n_stall); end
      checks++;
      if (perf_cycles_o !== 32'(n_busy)) begin failures++; $display("FAIL bp_perf_cycles got %0d want %0d", perf_cycles_o, n_busy); end
`endif
   endtask

   task automatic test_abort();
      int bad = 0;
      @(negedge clk);
      start_i = 1'b1;
      run_seq(0, 0, 20);
      checks++;
      if (hs_w.size() !== 21) begin failures++; $display("FAIL abort_point got %0d steps want 21", hs_w.size()); end
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || mac_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got busy=%b done=%b valid=%b want 0 0 0", busy_o, done_o, mac_valid_o);
      end
      repeat (5) begin
         @(negedge clk);
         if (done_o || busy_o) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
      start_i = 1'b1;
      run_seq(0, 0, -1);
      checks++;
      if (hs_w.size() !== 48 || hs_w[0] !== 0 || hs_x[0] !== 0) begin
         failures++;
         $display("FAIL abort_restart got steps=%0d w0=%0d x0=%0d want 48 0 0", hs_w.size(), hs_w.size() ? hs_w[0] : -1, hs_x.size() ? hs_x[0] : -1);
      end
      checks++;
      if (n_done !== 1) begin failures++; $display("FAIL abort_restart_done got %0d want 1", n_done); end
   endtask

   task automatic test_async_reset();
      int bad = 0;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      mac_ready_i = 1'b1;
      @(negedge clk);
      mac_ready_i = 1'b0;
      checks++;
      if (mac_valid_o !== 1'b1 || w_addr_o !== WA'(1)) begin
         failures++;
         $display("FAIL areset_pre got valid=%b w=%0d want 1 1", mac_valid_o, w_addr_o);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if ({mac_valid_o, mac_first_o, mac_last_o, w_addr_o, x_addr_o, b_addr_o, cell_upd_o, cell_unit_o, busy_o, done_o, step_t_o} !== '0) begin
         failures++;
         $display("FAIL areset_outputs got valid=%b busy=%b w=%0d want all 0", mac_valid_o, busy_o, w_addr_o);
      end
      @(negedge clk);
      rst_i = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mac_valid_o || busy_o || done_o || cell_upd_o) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL areset_quiet got %0d active cycles want 0", bad); end
      start_i = 1'b1;
      run_seq(0, 0, -1);
      checks++;
      if (hs_w.size() !== 48 || n_done !== 1 || !first_ok) begin
         failures++;
         $display("FAIL areset_restart got steps=%0d done=%0d first=%b want 48 1 1", hs_w.size(), n_done, first_ok);
      end
   endtask

   task automatic test_spurious();
      @(negedge clk);
      start_i = 1'b1;
      run_seq(0, 1, -1);
      checks++;
      if (timed_out || n_done !== 1) begin failures++; $display("FAIL spur_done got %0d timeout=%0d want 1", n_done, timed_out); end
      checks++;
      if (hs_w.size() !== 48) begin failures++; $display("FAIL spur_steps got %0d want 48", hs_w.size()); end
      for (int i = 0; i < hs_w.size() && i < 48; i++) begin
         checks++;
         if (hs_w[i] !== exp_w[i] || hs_x[i] !== exp_x[i] || hs_b[i] !== exp_b[i] || hs_fl[i] !== exp_fl[i]) begin
            failures++;
            $display("FAIL spur_step%0d got w=%0d x=%0d b=%0d want w=%0d x=%0d b=%0d",
                     i, hs_w[i], hs_x[i], hs_b[i], exp_w[i], exp_x[i], exp_b[i]);
         end
      end
      checks++;
      if (units.size() !== 4) begin failures++; $display("FAIL spur_cells got %0d want 4", units.size()); end
   endtask

   initial begin
      for (int i = 0; i < 48; i++) begin
         exp_w[i] = i % 24;
         exp_x[i] = (i / 24) * 3 + i % 3;
         exp_b[i] = (i % 24) / 3;
         exp_fl[i] = (i % 3 == 0 ? 2 : 0) + (i % 3 == 2 ? 1 : 0);
      end
      test_reset();
      test_load_gate();
      test_nominal();
      test_backpressure();
      test_abort();
      test_async_reset();
      test_spurious();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
